// File: rtl/traffic_pkg.sv
// traffic_pkg: light encodings, phase enum and error codes shared by controller and monitor
package traffic_pkg;
  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;
  typedef enum logic [1:0] {
    PH_SYNC   = 2'd0,
    PH_RED    = 2'd1,
    PH_GREEN  = 2'd2,
    PH_YELLOW = 2'd3
  } phase_e;
  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_BAD_ENC   = 3'd1;
  localparam logic [2:0] ERR_BAD_TRANS = 3'd2;
  localparam logic [2:0] ERR_SHORT     = 3'd3;
  localparam logic [2:0] ERR_LONG      = 3'd4;
  function automatic logic [2:0] next_light(phase_e p);
    return p == PH_RED ? LT_GRN : p == PH_GREEN ? LT_YEL : LT_RED;
  endfunction
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: loads 1 on clear, otherwise counts up and holds at all-ones
module dwell_counter
  import traffic_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] r_count;
  // restart at 1 when the observed value changes, saturate instead of wrapping
  always_ff @(posedge clk)
    if (!reset) r_count <= '0;
    else if (i_clear) r_count <= CNT_W'(1);
    else if (i_enable && r_count != '1) r_count <= r_count + 1'b1;
  assign o_count = r_count;
endmodule

// File: rtl/traffic_monitor.sv
// traffic_monitor: tracks an observed light sequence and flags encoding, order and dwell violations
module traffic_monitor
  import traffic_pkg::*;
#(
  parameter int RED_MIN   = 20,
  parameter int RED_MAX   = 40,
  parameter int GREEN_MIN = 20,
  parameter int GREEN_MAX = 40,
  parameter int YEL_MIN   = 5,
  parameter int YEL_MAX   = 10,
  parameter int CNT_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  lights,
  output logic [1:0]  phase,
  output logic        err_valid,
  output logic [2:0]  err_code,
  output logic        err_sticky,
  output logic [15:0] cycles_done
);
  logic [2:0]       r_lights_q, r_prev;
  phase_e           r_phase, w_phase_nxt;
  logic             r_exempt;
  logic [CNT_W-1:0] w_dwell;
  logic [CNT_W:0]   w_min, w_max;
  logic             w_chg, w_tracked, w_legal, w_bad_enc, w_bad_trans, w_short, w_long, w_y2r;
  logic [2:0]       w_code;

  dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_chg),
    .i_enable (1'b1),
    .o_count  (w_dwell)
  );

  assign w_chg       = r_lights_q != r_prev;
  assign w_tracked   = r_phase != PH_SYNC;
  assign w_legal     = r_lights_q == next_light(r_phase);
  assign w_min       = r_phase == PH_RED ? (CNT_W+1)'(RED_MIN) : r_phase == PH_GREEN ? (CNT_W+1)'(GREEN_MIN) : (CNT_W+1)'(YEL_MIN);
  assign w_max       = r_phase == PH_RED ? (CNT_W+1)'(RED_MAX) : r_phase == PH_GREEN ? (CNT_W+1)'(GREEN_MAX) : (CNT_W+1)'(YEL_MAX);
  assign w_bad_enc   = w_chg && !$onehot(r_lights_q);
  assign w_bad_trans = w_tracked && w_chg && $onehot(r_lights_q) && !w_legal;
  assign w_short     = w_tracked && w_chg && w_legal && !(r_phase == PH_RED && r_exempt) && {1'b0, w_dwell} < w_min;
  assign w_long      = w_tracked && !w_chg && {1'b0, w_dwell} == w_max && w_dwell != '1;
  assign w_y2r       = r_phase == PH_YELLOW && w_chg && w_legal;
  assign phase       = r_phase;

  // highest-priority violation and next tracked phase
  always_comb begin
    w_code      = w_bad_enc ? ERR_BAD_ENC : w_bad_trans ? ERR_BAD_TRANS : w_short ? ERR_SHORT : w_long ? ERR_LONG : ERR_NONE;
    w_phase_nxt = (w_bad_enc || w_bad_trans) ? PH_SYNC :
                  !w_tracked ? (r_lights_q == LT_RED ? PH_RED : PH_SYNC) :
                  !w_chg ? r_phase :
                  r_phase == PH_RED ? PH_GREEN : r_phase == PH_GREEN ? PH_YELLOW : PH_RED;
  end

  // input capture, phase tracking, error reporting and round counting
  always_ff @(posedge clk)
    if (!reset) begin
      r_lights_q  <= 3'b000;
      r_prev      <= 3'b000;
      r_phase     <= PH_SYNC;
      r_exempt    <= 1'b0;
      err_valid   <= 1'b0;
      err_code    <= ERR_NONE;
      err_sticky  <= 1'b0;
      cycles_done <= '0;
    end else begin
      r_lights_q  <= lights;
      r_prev      <= r_lights_q;
      r_phase     <= w_phase_nxt;
      r_exempt    <= !w_tracked || (r_exempt && w_phase_nxt == PH_RED);
      err_valid   <= w_code != ERR_NONE;
      err_code    <= w_code;
      err_sticky  <= err_sticky || w_code != ERR_NONE;
      if (w_y2r && cycles_done != 16'hFFFF) cycles_done <= cycles_done + 16'd1;
    end
endmodule

// File: tb/tb_traffic_monitor.sv
// tb_traffic_monitor: directed light sequences with a cycle-stamped scoreboard
module tb_traffic_monitor;
  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;
  localparam int K_PH = 0, K_CD = 1, K_ST = 2, K_EV = 3, K_EC = 4;
  localparam int LIMIT = 3000;

  typedef struct {int cyc; int kind; logic [15:0] val;} st_t;
  typedef struct {int cyc; logic [2:0] code;} er_t;

  logic        clk, reset;
  logic [2:0]  lights;
  logic [1:0]  phase;
  logic        err_valid, err_sticky;
  logic [2:0]  err_code;
  logic [15:0] cycles_done;

  st_t st_q[$];
  er_t er_q[$];
  int  compared = 0, mismatched = 0, cyc = 0;
  bit  done = 0;

  traffic_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .lights      (lights),
    .phase       (phase),
    .err_valid   (err_valid),
    .err_code    (err_code),
    .err_sticky  (err_sticky),
    .cycles_done (cycles_done)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(int k);
    return k == K_PH ? "phase" : k == K_CD ? "cycles_done" : k == K_ST ? "err_sticky" : k == K_EV ? "err_valid" : "err_code";
  endfunction

  function automatic logic [15:0] probe(int k);
    return k == K_PH ? 16'(phase) : k == K_CD ? cycles_done : k == K_ST ? 16'(err_sticky) : k == K_EV ? 16'(err_valid) : 16'(err_code);
  endfunction

  function automatic void exp_st(int off, int k, int v);
    st_t e;
    int i;
    e.cyc = cyc + off; e.kind = k; e.val = 16'(v);
    i = st_q.size();
    while (i > 0 && st_q[i-1].cyc > e.cyc) i--;
    st_q.insert(i, e);
  endfunction

  function automatic void exp_err(int off, int code);
    er_t e;
    int i;
    e.cyc = cyc + off; e.code = 3'(code);
    i = er_q.size();
    while (i > 0 && er_q[i-1].cyc > e.cyc) i--;
    er_q.insert(i, e);
  endfunction

  task automatic hold(input logic [2:0] lt, input int n);
    lights = lt;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void exp_reset_state();
    exp_st(0, K_PH, 0); exp_st(0, K_EV, 0); exp_st(0, K_EC, 0); exp_st(0, K_ST, 0); exp_st(0, K_CD, 0);
  endfunction

  // monitor: pairs every error pulse and every state check with its expectation
  always @(negedge clk) begin
    if (cyc >= 1 && err_valid === 1'b1) begin
      compared++;
      if (er_q.size() == 0) begin
        mismatched++;
        $display("FAIL err_pulse: got code %0d at cycle %0d, expected no pulse", err_code, cyc);
      end else begin
        if (er_q[0].cyc != cyc || er_q[0].code !== err_code) begin
          mismatched++;
          $display("FAIL err_pulse: got code %0d at cycle %0d, expected code %0d at cycle %0d", err_code, cyc, er_q[0].code, er_q[0].cyc);
        end
        er_q.delete(0);
      end
    end
    while (er_q.size() > 0 && er_q[0].cyc < cyc) begin
      compared++; mismatched++;
      $display("FAIL err_pulse: no pulse, expected code %0d at cycle %0d", er_q[0].code, er_q[0].cyc);
      er_q.delete(0);
    end
    while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
      compared++;
      if (probe(st_q[0].kind) !== st_q[0].val) begin
        mismatched++;
        $display("FAIL %s @%0d: got %0h expected %0h", kname(st_q[0].kind), cyc, probe(st_q[0].kind), st_q[0].val);
      end
      st_q.delete(0);
    end
    if (done || cyc > LIMIT) begin
      if (!done) begin
        compared++; mismatched++;
        $display("FAIL timeout: stimulus incomplete at cycle %0d, limit %0d", cyc, LIMIT);
      end
      foreach (er_q[i]) begin
        compared++; mismatched++;
        $display("FAIL err_pulse: never seen, expected code %0d at cycle %0d", er_q[i].code, er_q[i].cyc);
      end
      foreach (st_q[i]) begin
        compared++; mismatched++;
        $display("FAIL %s: never checked, expected %0h at cycle %0d", kname(st_q[i].kind), st_q[i].val, st_q[i].cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end
  end

  initial begin
    reset = 0;
    lights = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    exp_reset_state();
    reset = 1;
    for (int r = 0; r < 3; r++) begin
      exp_st(2, K_PH, 1); exp_st(2, K_CD, r); hold(RED, 25);
      exp_st(2, K_PH, 2); hold(GRN, 30);
      exp_st(2, K_PH, 3); hold(YEL, 7);
    end
    exp_st(2, K_PH, 1); exp_st(2, K_CD, 3); exp_st(41, K_ST, 0);
    exp_err(42, 4); exp_st(42, K_ST, 1); exp_st(42, K_PH, 1);
    hold(RED, 45);
    exp_st(2, K_PH, 2); hold(GRN, 10);
    exp_err(2, 3); exp_st(2, K_PH, 3); exp_st(2, K_ST, 1); hold(YEL, 7);
    exp_st(2, K_PH, 1); exp_st(2, K_CD, 4); hold(RED, 25);
    exp_err(2, 2); exp_st(2, K_PH, 0); hold(YEL, 5);
    exp_st(2, K_PH, 1); hold(RED, 8);
    exp_st(2, K_PH, 2); hold(GRN, 5);
    exp_err(2, 1); exp_st(2, K_PH, 0); hold(3'b110, 3);
    exp_st(2, K_PH, 1); hold(RED, 25);
    exp_st(2, K_PH, 2); hold(GRN, 15);
    reset = 0;
    hold(GRN, 1);
    exp_reset_state();
    reset = 1;
    exp_st(3, K_PH, 0); exp_st(4, K_ST, 0); hold(GRN, 5);
    exp_st(2, K_PH, 0); hold(YEL, 7);
    exp_st(2, K_PH, 1); exp_st(2, K_CD, 0); hold(RED, 25);
    exp_st(2, K_PH, 2); exp_st(2, K_ST, 0); hold(GRN, 21);
    done = 1;
  end
endmodule
